// File: rtl/wshb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wshb_arb_pkg
// Shared definitions for the two-requester Wishbone B4 arbiter:
//   - arb_state_t : arbiter ownership states (IDLE, GNT0, GNT1)
//   - REQ_MIRE / REQ_VGA : requester indices (test-pattern writer / VGA reader)
//   - Wishbone B4 CTI and BTE encodings
//   - state_to_grant : one-hot grant vector for a given ownership state
// -----------------------------------------------------------------------------
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    // Requester indices; also the bit positions in the grant vector
    localparam logic REQ_MIRE = 1'b0;
    localparam logic REQ_VGA  = 1'b1;

    // Wishbone B4 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone B4 burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // One-hot owner vector: bit REQ_MIRE for GNT0, bit REQ_VGA for GNT1
    function automatic logic [1:0] state_to_grant(input arb_state_t state);
        logic [1:0] grant_v;
        grant_v = 2'b00;
        case (state)
            GNT0:    grant_v[REQ_MIRE] = 1'b1;
            GNT1:    grant_v[REQ_VGA]  = 1'b1;
            default: grant_v = 2'b00;
        endcase
        return grant_v;
    endfunction

endpackage

// File: rtl/wshb_arb_watchdog.sv
// -----------------------------------------------------------------------------
// wshb_arb_watchdog
// Stall counter for the currently granted Wishbone cycle.
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low
//   clr    in   clear counter (ack seen or ownership about to change)
//   en     in   count this cycle (owner strobing, no ack)
//   fire   out  counter has reached TIMEOUT-1 while still stalled
// The counter is $clog2(TIMEOUT) bits wide, so TIMEOUT-1 is always
// representable. TIMEOUT must be at least 2.
// fire is combinational: the arbiter needs it in the same cycle to
// suppress m_cyc/m_stb and raise err. It is not gated by clr because clr
// itself depends on the ownership change that fire causes.
// -----------------------------------------------------------------------------
module wshb_arb_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic fire
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt_r;

    // Stall counter: clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign fire = en & (wd_cnt_r == LAST_CNT);

endmodule

// File: rtl/wshb_arbiter.sv
// -----------------------------------------------------------------------------
// wshb_arbiter
// Two-requester Wishbone B4 (classic/burst) arbiter in front of one master
// port (SDRAM side). Requester 0 is the test-pattern writer (mire),
// requester 1 the VGA framebuffer reader.
//
// Ownership is registered (one cycle grant latency from IDLE) and held for
// the whole cyc. Ties in IDLE go to the requester that did not own the bus
// last. A release with the other requester waiting hands over directly with
// no IDLE bubble. A per-grant watchdog terminates a cycle that has strobed
// TIMEOUT cycles without ack: err pulses to the owner, m_cyc/m_stb drop for
// that cycle and ownership is released.
//
// Parameters: ADDR_W (address width), DATA_W (data width, sel = DATA_W/8),
//             TIMEOUT (stalled cycles before the watchdog fires, >= 2)
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s{0,1}_cyc/stb/we/adr/sel/cti/bte/dat_ms   requester request side
//   s{0,1}_ack, s{0,1}_err          ack / watchdog err, owner only
//   s{0,1}_dat_sm                   read data, broadcast of m_dat_sm
//   m_cyc/stb/we/adr/sel/cti/bte/dat_ms        muxed from owner, 0 if none
//   m_ack, m_dat_sm                 slave response
//   grant                           one-hot owner, 2'b00 when idle
// Build option:
//   WSHB_ARB_VGA_PRIO_EN  when defined, requester 1 (VGA) wins every tie.
// -----------------------------------------------------------------------------
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // requester 0 (mire)
    input  logic                  s0_cyc,
    input  logic                  s0_stb,
    input  logic                  s0_we,
    input  logic [ADDR_W-1:0]     s0_adr,
    input  logic [DATA_W/8-1:0]   s0_sel,
    input  logic [2:0]            s0_cti,
    input  logic [1:0]            s0_bte,
    input  logic [DATA_W-1:0]     s0_dat_ms,
    output logic                  s0_ack,
    output logic                  s0_err,
    output logic [DATA_W-1:0]     s0_dat_sm,
    // requester 1 (VGA)
    input  logic                  s1_cyc,
    input  logic                  s1_stb,
    input  logic                  s1_we,
    input  logic [ADDR_W-1:0]     s1_adr,
    input  logic [DATA_W/8-1:0]   s1_sel,
    input  logic [2:0]            s1_cti,
    input  logic [1:0]            s1_bte,
    input  logic [DATA_W-1:0]     s1_dat_ms,
    output logic                  s1_ack,
    output logic                  s1_err,
    output logic [DATA_W-1:0]     s1_dat_sm,
    // master port
    output logic                  m_cyc,
    output logic                  m_stb,
    output logic                  m_we,
    output logic [ADDR_W-1:0]     m_adr,
    output logic [DATA_W/8-1:0]   m_sel,
    output logic [2:0]            m_cti,
    output logic [1:0]            m_bte,
    output logic [DATA_W-1:0]     m_dat_ms,
    input  logic                  m_ack,
    input  logic [DATA_W-1:0]     m_dat_sm,
    // current owner
    output logic [1:0]            grant
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_t state_r;
    arb_state_t state_next_s;
    arb_state_t tie_winner_s;
    logic       last_owner_r;
    logic       last_owner_next_s;
    logic       own_stb_s;
    logic       wd_en_s;
    logic       wd_clr_s;
    logic       wd_fire_s;

    // Strobe of whoever currently owns the bus (0 when idle)
    always_comb begin
        own_stb_s = 1'b0;
        case (state_r)
            GNT0:    own_stb_s = s0_stb;
            GNT1:    own_stb_s = s1_stb;
            default: own_stb_s = 1'b0;
        endcase
    end

    // Count only stalled strobes; any ack or ownership change restarts the count
    assign wd_en_s  = own_stb_s & ~m_ack;
    assign wd_clr_s = m_ack | (state_next_s != state_r);

    wshb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr_s),
        .en    (wd_en_s),
        .fire  (wd_fire_s)
    );

    // Winner when both requesters raise cyc together in IDLE
    always_comb begin
        tie_winner_s = GNT0;
`ifdef WSHB_ARB_VGA_PRIO_EN
        tie_winner_s = GNT1;
`else
        if (last_owner_r == REQ_VGA) begin
            tie_winner_s = GNT0;
        end else begin
            tie_winner_s = GNT1;
        end
`endif
    end

    // Next ownership: hold while owner keeps cyc, release on cyc drop or watchdog
    always_comb begin
        state_next_s      = state_r;
        last_owner_next_s = last_owner_r;
        case (state_r)
            IDLE: begin
                if (s0_cyc && s1_cyc) begin
                    state_next_s = tie_winner_s;
                end else if (s0_cyc) begin
                    state_next_s = GNT0;
                end else if (s1_cyc) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT0: begin
                if (!s0_cyc || wd_fire_s) begin
                    last_owner_next_s = REQ_MIRE;
                    state_next_s      = s1_cyc ? GNT1 : IDLE;
                end else begin
                    state_next_s      = GNT0;
                end
            end
            GNT1: begin
                if (!s1_cyc || wd_fire_s) begin
                    last_owner_next_s = REQ_VGA;
                    state_next_s      = s0_cyc ? GNT0 : IDLE;
                end else begin
                    state_next_s      = GNT1;
                end
            end
            default: begin
                state_next_s      = IDLE;
                last_owner_next_s = last_owner_r;
            end
        endcase
    end

    // Ownership and round-robin history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_owner_r <= REQ_VGA;
        end else begin
            state_r      <= state_next_s;
            last_owner_r <= last_owner_next_s;
        end
    end

    // Master-side mux from the registered owner; ack/err routed to owner only.
    // cyc/stb pass straight through so a cyc drop reaches the slave the same
    // cycle, and both are forced low in the cycle the watchdog terminates.
    always_comb begin
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        m_adr    = {ADDR_W{1'b0}};
        m_sel    = {SEL_W{1'b0}};
        m_cti    = 3'b000;
        m_bte    = 2'b00;
        m_dat_ms = {DATA_W{1'b0}};
        s0_ack   = 1'b0;
        s0_err   = 1'b0;
        s1_ack   = 1'b0;
        s1_err   = 1'b0;
        case (state_r)
            GNT0: begin
                m_cyc    = s0_cyc & ~wd_fire_s;
                m_stb    = s0_stb & ~wd_fire_s;
                m_we     = s0_we;
                m_adr    = s0_adr;
                m_sel    = s0_sel;
                m_cti    = s0_cti;
                m_bte    = s0_bte;
                m_dat_ms = s0_dat_ms;
                s0_ack   = m_ack;
                s0_err   = wd_fire_s;
            end
            GNT1: begin
                m_cyc    = s1_cyc & ~wd_fire_s;
                m_stb    = s1_stb & ~wd_fire_s;
                m_we     = s1_we;
                m_adr    = s1_adr;
                m_sel    = s1_sel;
                m_cti    = s1_cti;
                m_bte    = s1_bte;
                m_dat_ms = s1_dat_ms;
                s1_ack   = m_ack;
                s1_err   = wd_fire_s;
            end
            default: begin
                m_cyc    = 1'b0;
                m_stb    = 1'b0;
            end
        endcase
    end

    assign s0_dat_sm = m_dat_sm;
    assign s1_dat_sm = m_dat_sm;
    assign grant     = state_to_grant(state_r);

endmodule
